// File: rtl/hamming_secded_decoder_pipe_if.sv
// rtl/hamming_secded_decoder_pipe_if.sv - stream and counter signals of the SECDED decoder pipe
// master drives codewords and controls; slave is the decoder.
interface hamming_secded_decoder_pipe_if #(
  parameter int R     = 4,
  parameter int CNT_W = 16
);
  localparam int N = 1 << R;
  localparam int K = N - R - 1;

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_code;
  logic             correct_en;
  logic             out_valid;
  logic             out_ready;
  logic [K-1:0]     out_data;
  logic             out_single;
  logic             out_double;
  logic [R-1:0]     out_err_pos;
  logic             cnt_clr;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] uncorr_count;

  modport master (
    output in_valid, in_code, correct_en, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, out_single, out_double, out_err_pos,
           corr_count, uncorr_count
  );

  modport slave (
    input  in_valid, in_code, correct_en, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, out_single, out_double, out_err_pos,
           corr_count, uncorr_count
  );
endinterface

// File: rtl/hamming_secded_decoder_pipe.sv
// rtl/hamming_secded_decoder_pipe.sv - two-stage valid/ready SECDED Hamming decoder with error counters
// Stage 1 registers codeword, syndrome and overall parity; stage 2 classifies, corrects and extracts data.
module hamming_secded_decoder_pipe #(
  parameter int R     = 4,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  hamming_secded_decoder_pipe_if.slave bus
);
  localparam int N = 1 << R;
  localparam int K = N - R - 1;

  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     s1_code_q, s1_code_d;
  logic [R-1:0]     s1_syn_q, s1_syn_d;
  logic             s1_pe_q, s1_pe_d;
  logic             s1_cen_q, s1_cen_d;

  logic             out_valid_q, out_valid_d;
  logic [K-1:0]     out_data_q, out_data_d;
  logic             out_single_q, out_single_d;
  logic             out_double_q, out_double_d;
  logic [R-1:0]     out_err_pos_q, out_err_pos_d;

  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] uncorr_q, uncorr_d;

  logic             s2_ready;
  logic             in_ready;
  logic             out_fire;
  logic [R-1:0]     syn_in;
  logic             is_single;
  logic             is_double;
  logic [N-1:0]     flip_mask;
  logic [N-1:0]     fixed_code;
  logic [K-1:0]     data_x;

  // Syndrome bit i covers every position whose index has bit i set.
  always_comb begin
    syn_in = '0;
    for (int p = 1; p < N; p++) begin
      for (int i = 0; i < R; i++) begin
        if (((p >> i) & 1) != 0) begin
          syn_in[i] = syn_in[i] ^ bus.in_code[p];
        end
      end
    end
  end

  always_comb begin
    is_single  = s1_pe_q;
    is_double  = !s1_pe_q && (s1_syn_q != '0);
    flip_mask  = (is_single && s1_cen_q) ? (N'(1) << s1_syn_q) : '0;
    fixed_code = s1_code_q ^ flip_mask;
  end

  // Data sits at every non-power-of-two position from 3 upward, in ascending order.
  always_comb begin
    int j;
    j      = 0;
    data_x = '0;
    for (int p = 3; p < N; p++) begin
      if ((p & (p - 1)) != 0) begin
        data_x[j] = fixed_code[p];
        j         = j + 1;
      end
    end
  end

  always_comb begin
    s2_ready = !out_valid_q || bus.out_ready;
    in_ready = !s1_valid_q || s2_ready;
    out_fire = out_valid_q && bus.out_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_pe_d    = s1_pe_q;
    s1_cen_d   = s1_cen_q;
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_code_d = bus.in_code;
        s1_syn_d  = syn_in;
        s1_pe_d   = ^bus.in_code;
        s1_cen_d  = bus.correct_en;
      end
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_single_d  = out_single_q;
    out_double_d  = out_double_q;
    out_err_pos_d = out_err_pos_q;
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d    = data_x;
        out_single_d  = is_single;
        out_double_d  = is_double;
        out_err_pos_d = is_single ? s1_syn_q : '0;
      end
    end
  end

  // Clear wins over a same-cycle event, so that event is deliberately lost.
  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (bus.cnt_clr) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else begin
      if (out_fire && out_single_q && (corr_q != '1)) begin
        corr_d = corr_q + CNT_W'(1);
      end
      if (out_fire && out_double_q && (uncorr_q != '1)) begin
        uncorr_d = uncorr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_code_q     <= '0;
      s1_syn_q      <= '0;
      s1_pe_q       <= 1'b0;
      s1_cen_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_single_q  <= 1'b0;
      out_double_q  <= 1'b0;
      out_err_pos_q <= '0;
      corr_q        <= '0;
      uncorr_q      <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_code_q     <= s1_code_d;
      s1_syn_q      <= s1_syn_d;
      s1_pe_q       <= s1_pe_d;
      s1_cen_q      <= s1_cen_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_single_q  <= out_single_d;
      out_double_q  <= out_double_d;
      out_err_pos_q <= out_err_pos_d;
      corr_q        <= corr_d;
      uncorr_q      <= uncorr_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_single   = out_single_q;
  assign bus.out_double   = out_double_q;
  assign bus.out_err_pos  = out_err_pos_q;
  assign bus.corr_count   = corr_q;
  assign bus.uncorr_count = uncorr_q;

endmodule

// File: tb/tb_hamming_secded_decoder_pipe.sv
// tb/tb_hamming_secded_decoder_pipe.sv - scoreboard bench for the SECDED decoder pipe (R=4, CNT_W=2)
module tb_hamming_secded_decoder_pipe;
  localparam int R     = 4;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hamming_secded_decoder_pipe_if #(.R(R), .CNT_W(CNT_W)) bus();

  hamming_secded_decoder_pipe #(.R(R), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [16:0] sb[$];
  logic [16:0] exp_w;

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    logic        par;
    int          j;
    c = '0;
    j = 0;
    for (int p = 3; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      par = 1'b0;
      for (int p = 1; p < 16; p++) begin
        if ((((p >> i) & 1) != 0) && (p != (1 << i))) par = par ^ c[p];
      end
      c[1 << i] = par;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int p = 3; p < 16; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p];
        j++;
      end
    end
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL out_word: unexpected word got=%h required=none",
                   {bus.out_data, bus.out_single, bus.out_double, bus.out_err_pos});
        end else begin
          exp_w = sb.pop_front();
          if ({bus.out_data, bus.out_single, bus.out_double, bus.out_err_pos} !== exp_w) begin
            n_bad++;
            $display("FAIL out_word: got data=%h s=%b d=%b pos=%0d required data=%h s=%b d=%b pos=%0d",
                     bus.out_data, bus.out_single, bus.out_double, bus.out_err_pos,
                     exp_w[16:6], exp_w[5], exp_w[4], exp_w[3:0]);
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the handshake with in_valid still high.
  task automatic drive(input logic [15:0] c, input logic cen, input logic [16:0] e);
    int  t;
    bit  ok;
    bus.in_valid   = 1'b1;
    bus.in_code    = c;
    bus.correct_en = cen;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 300) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else t++;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drive_timeout: in_ready got=0 required=1");
    end else begin
      sb.push_back(e);
    end
    step();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      step();
      t++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending got=%0d required=0", sb.size());
    end
    step();
    step();
  endtask

  task automatic check_counts(input string name, input int corr, input int uncorr);
    n_cmp++;
    if (bus.corr_count !== CNT_W'(corr) || bus.uncorr_count !== CNT_W'(uncorr)) begin
      n_bad++;
      $display("FAIL %s: got corr=%0d uncorr=%0d required corr=%0d uncorr=%0d",
               name, bus.corr_count, bus.uncorr_count, corr, uncorr);
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_code    = '0;
    bus.correct_en = 1'b1;
    bus.out_ready  = 1'b1;
    bus.cnt_clr    = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_single, bus.out_double, bus.out_err_pos} !== {1'b1, 1'b0, 11'h0, 1'b0, 1'b0, 4'h0}) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b data=%h s=%b d=%b pos=%0d required rdy=1 vld=0 data=0 s=0 d=0 pos=0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.out_single, bus.out_double, bus.out_err_pos);
    end
    check_counts("reset_counts", 0, 0);
    step();
  endtask

  task automatic test_clean();
    drive(16'h000F, 1'b1, {11'h001, 1'b0, 1'b0, 4'd0});
    idle();
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_c1: out_valid got=%b required=0", bus.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_c2: out_valid got=%b required=1", bus.out_valid);
    end
    step();
    wait_drain();
    check_counts("clean_counts", 0, 0);
  endtask

  task automatic test_single();
    drive(16'h002F, 1'b1, {11'h001, 1'b1, 1'b0, 4'd5});
    idle();
    wait_drain();
    check_counts("single_corr", 1, 0);
    drive(16'h002F, 1'b0, {11'h003, 1'b1, 1'b0, 4'd5});
    idle();
    wait_drain();
    check_counts("single_detect", 2, 0);
  endtask

  task automatic test_double();
    drive(16'h000E, 1'b1, {11'h001, 1'b1, 1'b0, 4'd0});
    idle();
    wait_drain();
    check_counts("single_bit0", 3, 0);
    drive(16'hFFD7, 1'b1, {11'h7FC, 1'b0, 1'b1, 4'd0});
    idle();
    wait_drain();
    check_counts("double", 3, 1);
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(encode(11'h123), 1'b1, {11'h123, 1'b0, 1'b0, 4'd0});
    drive(encode(11'h456), 1'b1, {11'h456, 1'b0, 1'b0, 4'd0});
    bus.in_code = encode(11'h789);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.out_data} !== {1'b0, 1'b1, 11'h123}) begin
        n_bad++;
        $display("FAIL stall_%0d: got rdy=%b vld=%b data=%h required rdy=0 vld=1 data=123",
                 k, bus.in_ready, bus.out_valid, bus.out_data);
      end
    end
    step();
    bus.out_ready = 1'b1;
    drive(encode(11'h789), 1'b1, {11'h789, 1'b0, 1'b0, 4'd0});
    idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.in_ready} !== 2'b11) begin
        n_bad++;
        $display("FAIL release_%0d: got vld=%b rdy=%b required vld=1 rdy=1", k, bus.out_valid, bus.in_ready);
      end
    end
    step();
    wait_drain();
  endtask

  task automatic test_saturate();
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    check_counts("clr", 0, 0);
    for (int k = 0; k < 5; k++) drive(16'h002F, 1'b1, {11'h001, 1'b1, 1'b0, 4'd5});
    idle();
    wait_drain();
    check_counts("saturate", 3, 0);
    drive(16'h002F, 1'b1, {11'h001, 1'b1, 1'b0, 4'd5});
    idle();
    @(negedge clk);
    @(negedge clk);
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    check_counts("clr_priority", 0, 0);
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    drive(16'h002F, 1'b1, {11'h001, 1'b1, 1'b0, 4'd5});
    drive(16'hFFD7, 1'b1, {11'h7FC, 1'b0, 1'b1, 4'd0});
    idle();
    wait_drain();
    check_counts("pre_reset", 1, 1);
    bus.out_ready = 1'b0;
    drive(encode(11'h555), 1'b1, {11'h555, 1'b0, 1'b0, 4'd0});
    drive(encode(11'h2AA), 1'b1, {11'h2AA, 1'b0, 1'b0, 4'd0});
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL midflight_reset: got vld=%b rdy=%b required vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
    check_counts("midflight_counts", 0, 0);
    step();
    bus.out_ready = 1'b1;
    drive(16'hFFFF, 1'b1, {11'h7FF, 1'b0, 1'b0, 4'd0});
    idle();
    wait_drain();
    repeat (4) step();
  endtask

  task automatic test_random();
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [10:0] d;
          logic [15:0] c;
          logic        cen;
          int          kind, p1, p2;
          d    = 11'($urandom);
          c    = encode(d);
          cen  = 1'($urandom_range(0, 1));
          kind = $urandom_range(0, 2);
          if (kind == 0) begin
            drive(c, cen, {d, 1'b0, 1'b0, 4'd0});
          end else if (kind == 1) begin
            p1 = $urandom_range(0, 15);
            c  = c ^ (16'h0001 << p1);
            drive(c, cen, {(cen ? d : extract(c)), 1'b1, 1'b0, 4'(p1)});
          end else begin
            p1 = $urandom_range(0, 15);
            p2 = (p1 + $urandom_range(1, 15)) % 16;
            c  = c ^ (16'h0001 << p1) ^ (16'h0001 << p2);
            drive(c, cen, {extract(c), 1'b0, 1'b1, 4'd0});
          end
          if ($urandom_range(0, 3) == 0) begin
            idle();
            step();
          end
        end
        idle();
      end
      begin
        for (int k = 0; k < 150; k++) begin
          step();
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_back_to_back();
    test_saturate();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
